// File: rtl/lvds_clk_gen.sv
// Purpose: multi-channel refclk divider/phase generator with lock FSM and runtime reconfiguration.
// Latency: outputs registered; an accepted write drops locked next cycle, realigns, and relocks LOCK_CYCLES after t0.
// Backpressure: cfg_ready only in SETTLE/LOCKED; invalid writes are dropped and flagged on cfg_err one cycle later.
module lvds_clk_gen #(
  parameter  int N_OUT       = 2,
  parameter  int DIV_W       = 8,
  parameter  int DEFAULT_DIV = 8,
  parameter  int LOCK_CYCLES = 16,
  localparam int SEL_W       = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase,
  output logic             cfg_err,
  output logic [N_OUT-1:0] outclk,
  output logic [N_OUT-1:0] outclk_stb,
  output logic             locked
);

  localparam int SCNT_W = $clog2(LOCK_CYCLES) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SCNT_W-1:0]   settle_q, settle_d;
  logic [DIV_W-1:0]    div_q    [N_OUT];
  logic [DIV_W-1:0]    div_d    [N_OUT];
  logic [DIV_W-1:0]    phase_q  [N_OUT];
  logic [DIV_W-1:0]    phase_d  [N_OUT];
  logic [DIV_W-1:0]    ph_cnt_q [N_OUT];
  logic [DIV_W-1:0]    ph_cnt_d [N_OUT];
  logic [DIV_W-1:0]    per_cnt_q[N_OUT];
  logic [DIV_W-1:0]    per_cnt_d[N_OUT];
  logic [N_OUT-1:0]    outclk_q, outclk_d;
  logic [N_OUT-1:0]    stb_q, stb_d;
  logic [N_OUT-1:0]    ch_en;
  logic                locked_q, locked_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                wr_ok, accept, reject, run;

  // Ready is masked by rst so nothing is accepted in a reset cycle.
  assign cfg_ready  = ready_q & ~rst;
  assign cfg_err    = err_q;
  assign outclk     = outclk_q;
  assign outclk_stb = stb_q;
  assign locked     = locked_q;

  // Write qualification: channel must exist and phase must fit inside an enabled period.
  always_comb begin
    wr_ok  = (32'(cfg_sel) < N_OUT) &&
             ((cfg_div <= DIV_W'(1)) || (cfg_phase < cfg_div));
    accept = cfg_valid && cfg_ready && wr_ok;
    reject = cfg_valid && cfg_ready && !wr_ok;
  end

  // Lock FSM next state, settle counter and registered status flags.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      ST_IDLE:  state_d = ST_ALIGN;
      ST_ALIGN: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
      ST_SETTLE: begin
        if (accept) begin
          state_d = ST_ALIGN;
        end else if (settle_q == SCNT_W'(LOCK_CYCLES - 1)) begin
          state_d = ST_LOCKED;
        end
        if (settle_q != '1) settle_d = settle_q + SCNT_W'(1);
      end
      ST_LOCKED: begin
        if (accept) state_d = ST_ALIGN;
        if (settle_q != '1) settle_d = settle_q + SCNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    run      = (state_d == ST_SETTLE) || (state_d == ST_LOCKED);
    locked_d = (state_d == ST_LOCKED);
    ready_d  = run;
    err_d    = reject;
  end

  // Per-channel shadow update and counters; outputs are decoded from next-cycle counter values.
  always_comb begin
    ch_en    = '0;
    outclk_d = '0;
    stb_d    = '0;
    for (int i = 0; i < N_OUT; i++) begin
      div_d[i]     = div_q[i];
      phase_d[i]   = phase_q[i];
      ph_cnt_d[i]  = '0;
      per_cnt_d[i] = '0;
      if (accept && (32'(cfg_sel) == i)) begin
        div_d[i]   = cfg_div;
        phase_d[i] = cfg_phase;
      end
      if (state_q == ST_ALIGN) begin
        ph_cnt_d[i] = phase_q[i];
      end else if (run) begin
        if (ph_cnt_q[i] != '0) begin
          ph_cnt_d[i]  = ph_cnt_q[i] - DIV_W'(1);
        end else if ((div_q[i] > DIV_W'(1)) &&
                     (per_cnt_q[i] != div_q[i] - DIV_W'(1))) begin
          per_cnt_d[i] = per_cnt_q[i] + DIV_W'(1);
        end
      end
      ch_en[i]    = run && (div_q[i] > DIV_W'(1)) && (ph_cnt_d[i] == '0);
      outclk_d[i] = ch_en[i] && (per_cnt_d[i] < (div_q[i] >> 1));
      stb_d[i]    = ch_en[i] && (per_cnt_d[i] == '0);
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      outclk_q <= '0;
      stb_q    <= '0;
      locked_q <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
        div_q[i]     <= DIV_W'(DEFAULT_DIV);
        phase_q[i]   <= '0;
        ph_cnt_q[i]  <= '0;
        per_cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      outclk_q <= outclk_d;
      stb_q    <= stb_d;
      locked_q <= locked_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      for (int i = 0; i < N_OUT; i++) begin
        div_q[i]     <= div_d[i];
        phase_q[i]   <= phase_d[i];
        ph_cnt_q[i]  <= ph_cnt_d[i];
        per_cnt_q[i] <= per_cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_lvds_clk_gen.sv
// Purpose: directed + random bench for lvds_clk_gen against a cycle-index reference model.
// Latency: model predicts outputs for each cycle from (cycle - t0), divide and phase.
// Backpressure: writes offered regardless of cfg_ready; model ignores them when not ready.
module tb_lvds_clk_gen;
  // Three channels so that an out-of-range select (3) is encodable on the 2-bit select.
  localparam int N   = 3;
  localparam int DW  = 8;
  localparam int DEF = 8;
  localparam int LK  = 16;
  localparam int SW  = 2;
  localparam int FAR = 1 << 30;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [SW-1:0] cfg_sel = '0;
  logic [DW-1:0] cfg_div = '0;
  logic [DW-1:0] cfg_phase = '0;
  logic          cfg_ready, cfg_err, locked;
  logic [N-1:0]  outclk, outclk_stb;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycle index, start-of-run cycle, shadow config.
  int cyc;
  int t0;
  bit idle;
  bit err_now, err_nxt;
  int m_div[N];
  int m_ph[N];

  lvds_clk_gen #(.N_OUT(N), .DIV_W(DW), .DEFAULT_DIV(DEF), .LOCK_CYCLES(LK)) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .outclk(outclk), .outclk_stb(outclk_stb), .locked(locked)
  );

  always #5 refclk = ~refclk;

  // Expected clock (want_stb=0) or strobe (want_stb=1) vector for cycle c.
  function automatic logic [N-1:0] exp_vec(input int c, input bit want_stb);
    logic [N-1:0] v;
    int k, m;
    v = '0;
    for (int ch = 0; ch < N; ch++) begin
      k = c - t0;
      if (c >= t0 && m_div[ch] >= 2 && k >= m_ph[ch]) begin
        m = (k - m_ph[ch]) % m_div[ch];
        v[ch] = want_stb ? (m == 0) : (m < m_div[ch] / 2);
      end
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic set_defaults();
    for (int ch = 0; ch < N; ch++) begin
      m_div[ch] = DEF;
      m_ph[ch]  = 0;
    end
  endtask

  // One refclk cycle: drive inputs, check this cycle's outputs, advance the model.
  task automatic step(input bit v, input int sel, input int dv, input int ph, input bit r);
    rst       = r;
    cfg_valid = v;
    cfg_sel   = SW'(sel);
    cfg_div   = DW'(dv);
    cfg_phase = DW'(ph);
    @(negedge refclk);
    chk("outclk",     8'(outclk),     8'(exp_vec(cyc, 1'b0)));
    chk("outclk_stb", 8'(outclk_stb), 8'(exp_vec(cyc, 1'b1)));
    chk("locked",     8'(locked),     8'(cyc >= t0 + LK));
    chk("cfg_ready",  8'(cfg_ready),  8'((cyc >= t0) && !r));
    chk("cfg_err",    8'(cfg_err),    8'(err_now));
    err_nxt = 1'b0;
    if (r) begin
      idle = 1'b1;
      t0   = FAR;
      set_defaults();
    end else if (idle) begin
      idle = 1'b0;
      t0   = cyc + 2;
    end else if (v && cyc >= t0) begin
      if (sel < N && (dv <= 1 || ph < dv)) begin
        m_div[sel] = dv;
        m_ph[sel]  = ph;
        t0 = cyc + 2;
      end else begin
        err_nxt = 1'b1;
      end
    end
    @(posedge refclk);
    #1;
    cyc++;
    err_now = err_nxt;
  endtask

  task automatic idle_n(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic write(input int sel, input int dv, input int ph);
    step(1'b1, sel, dv, ph, 1'b0);
  endtask

  initial begin
    @(posedge refclk);
    #1;
    cyc = 0; t0 = FAR; idle = 1'b1; err_now = 1'b0; err_nxt = 1'b0;
    set_defaults();
    step(1'b0, 0, 0, 0, 1'b1);      // reset state
    idle_n(40);                     // defaults: D=8 P=0, lock after 16
    write(1, 8, 3);                 // ch1 delayed by 3
    idle_n(30);
    write(0, 5, 0);                 // odd divide 1,1,0,0,0
    idle_n(30);
    write(0, 4, 4);                 // phase not < div: rejected
    idle_n(4);
    write(3, 8, 0);                 // nonexistent channel: rejected
    idle_n(4);
    write(1, 1, 0);                 // ch1 disabled
    idle_n(30);
    write(2, 6, 2);
    write(1, 9, 0);                 // lands in ALIGN: ignored, no error
    idle_n(30);
    write(0, 8, 0);
    idle_n(8);                      // up to t0+7
    step(1'b0, 0, 0, 0, 1'b1);      // reset mid-SETTLE
    idle_n(40);
    write(0, 2, 1);
    idle_n(25);
    for (int j = 0; j < 500; j++) begin
      step(($urandom % 12) == 0, int'($urandom % 4), int'($urandom_range(0, 12)),
           int'($urandom_range(0, 12)), ($urandom % 150) == 0);
    end
    idle_n(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
